// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings and
// the baud divider helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DEF_BAUD       = 115200;
  localparam int DEF_OVERSAMPLE = 16;

  // System clocks per oversample tick, truncated.
  function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Enable-gated oversample tick generator. Produces one tick every DIV
// clocks, counts ticks modulo OVERSAMPLE and flags the mid-bit tick.
// Held at zero while disabled or cleared so every frame starts aligned.
module uart_baud_tick #(
  parameter int DIV        = 27,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          enable,
  output logic                          tick,
  output logic [$clog2(OVERSAMPLE)-1:0] tick_cnt,
  output logic                          sample
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);

  logic [DW-1:0] div_cnt;

  assign tick   = enable && (div_cnt == DIV_LAST);
  assign sample = tick && (tick_cnt == MID_CNT);

  // Clock divider and tick counter; wraps naturally since OVERSAMPLE is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else if (clear || !enable) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      tick_cnt <= tick_cnt + TW'(1);
    end else begin
      div_cnt  <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: synchronises the RX line, detects the start edge, samples
// each bit mid-period and hands bytes out through a one-entry ready/valid
// buffer. Reports framing errors (pulse) and overruns (sticky).
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 o_parity_err,
`endif
  input  logic                 i_clr_err
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 fall;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic [TW-1:0]        tick_cnt;
  logic                 mid_sample;
  logic                 bit_pt;
  logic                 start_ok;
  logic                 cnt_clear;

  // Two-flop synchroniser plus a delay flop for edge detection; preset high (idle line).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  // The start bit is checked mid-bit; the counter is then realigned so every
  // following bit is sampled one full bit period (OVERSAMPLE ticks) later.
  assign start_ok  = (state == START) && mid_sample && !rx_s;
  assign cnt_clear = (state == IDLE) || start_ok;
  assign bit_pt    = tick && (tick_cnt == LAST_TICK);
  assign o_busy    = (state != IDLE);

  uart_baud_tick #(
    .DIV        (DIV),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (state != IDLE),
    .tick     (tick),
    .tick_cnt (tick_cnt),
    .sample   (mid_sample)
  );

  // Frame FSM with output buffer and error flags; a same-cycle overrun beats i_clr_err.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_frame_err <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (i_clr_err) begin
        o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
        o_parity_err <= 1'b0;
`endif
      end
      case (state)
        IDLE: begin
          if (fall) state <= START;
        end
        START: begin
          if (mid_sample) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (bit_pt) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_pt) begin
            if ((^shreg ^ rx_s) != PARITY_ODD) o_parity_err <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_pt) begin
            state <= IDLE;
            if (!rx_s) begin
              o_frame_err <= 1'b1;
            end else if (!o_valid || i_ready) begin
              o_data  <= shreg;
              o_valid <= 1'b1;
            end else begin
              o_overrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed testbench for uart_rx_deser at 50 MHz / 115200 baud (432 clk/bit).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit
// after a rising edge. Parity case is built when UART_RX_PARITY_EN is defined.
module tb_uart_rx_deser;

  localparam int BIT = 432;
`ifdef UART_RX_PARITY_EN
  localparam int HEAD = 10 * BIT;
`else
  localparam int HEAD = 9 * BIT;
`endif

  logic       clock;
  logic       reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_busy;
  logic       o_frame_err;
  logic       o_overrun;
  logic       i_clr_err;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_deser dut (
    .clock        (clock),
    .reset        (reset),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
`ifdef UART_RX_PARITY_EN
    .o_parity_err (o_parity_err),
`endif
    .i_clr_err    (i_clr_err)
  );

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the line at level b for n clocks; returns 1 unit after a rising edge.
  task automatic send_bits(input logic b, input int n);
    i_rx = b;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Start bit, LSB-first data and (when built) a parity bit; stop bit is left to the caller.
  task automatic send_head(input logic [7:0] d, input logic par_flip);
    logic par;
    par = (^d) ^ par_flip;
    send_bits(1'b0, BIT);
    for (int j = 0; j < 8; j++) send_bits(d[j], BIT);
`ifdef UART_RX_PARITY_EN
    send_bits(par, BIT);
`else
    if (par) i_rx = 1'b1;
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    send_head(d, par_flip);
    send_bits(stop_bit, BIT);
  endtask

  initial begin
    reset     = 1'b1;
    i_rx      = 1'b1;
    i_ready   = 1'b1;
    i_clr_err = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_data", o_data, 32'h0);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ferr", o_frame_err, 0);
    check("rst_ovr", o_overrun, 0);
    reset = 1'b0;
    send_bits(1'b1, 10);

    // 0xA5: o_valid rises on the edge 219 clocks into the stop bit and lasts one cycle.
    send_head(8'hA5, 1'b0);
    send_bits(1'b1, 218);
    check("a5_early", o_valid, 0);
    send_bits(1'b1, 1);
    check("a5_valid", o_valid, 1);
    check("a5_data", o_data, 32'hA5);
    check("a5_ferr", o_frame_err, 0);
    check("a5_busy", o_busy, 0);
    send_bits(1'b1, 1);
    check("a5_pulse", o_valid, 0);
    send_bits(1'b1, BIT - 220);
`ifdef UART_RX_PARITY_EN
    check("a5_perr", o_parity_err, 0);
`endif

    // 100-clock low glitch: rejected at the start-bit sample point.
    send_bits(1'b0, 100);
    check("gl_busy_mid", o_busy, 1);
    send_bits(1'b1, 300);
    check("gl_busy", o_busy, 0);
    check("gl_valid", o_valid, 0);
    check("gl_ferr", o_frame_err, 0);

    // 0x3C with a low stop bit: one-cycle frame error, no byte; then break recovery.
    send_head(8'h3C, 1'b0);
    send_bits(1'b0, 219);
    check("fe_pulse", o_frame_err, 1);
    check("fe_valid", o_valid, 0);
    send_bits(1'b0, 1);
    check("fe_clear", o_frame_err, 0);
    send_bits(1'b0, BIT);
    check("brk_busy", o_busy, 0);
    send_bits(1'b1, 2 * BIT);
    check("brk_idle", o_busy, 0);
    check("brk_valid", o_valid, 0);

    // Back-to-back 0x11, 0x22 with consumer stalled: second byte dropped.
    i_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    check("ov_first_valid", o_valid, 1);
    check("ov_first_ovr", o_overrun, 0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ov_data", o_data, 32'h11);
    check("ov_valid", o_valid, 1);
    check("ov_flag", o_overrun, 1);
    i_ready = 1'b1;
    send_bits(1'b1, 1);
    check("ov_consumed", o_valid, 0);
    check("ov_sticky", o_overrun, 1);
    i_clr_err = 1'b1;
    send_bits(1'b1, 1);
    i_clr_err = 1'b0;
    check("ov_cleared", o_overrun, 0);
    send_bits(1'b1, 20);

    // Reset in the middle of 0xFF data, then a clean 0x5A.
    send_bits(1'b0, BIT);
    send_bits(1'b1, 3 * BIT);
    check("ab_busy_pre", o_busy, 1);
    reset = 1'b1;
    send_bits(1'b1, 2);
    check("ab_busy", o_busy, 0);
    check("ab_valid", o_valid, 0);
    reset = 1'b0;
    send_bits(1'b1, 7 * BIT);
    check("ab_no_byte", o_valid, 0);
    i_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0);
    check("ab_valid_5a", o_valid, 1);
    check("ab_data_5a", o_data, 32'h5A);
    i_ready = 1'b1;
    send_bits(1'b1, 1);
    check("ab_consumed", o_valid, 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 with parity bit 0 under even parity: delivered, parity error flagged.
    i_ready = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_valid", o_valid, 1);
    check("par_data", o_data, 32'h07);
    check("par_err", o_parity_err, 1);
    i_ready   = 1'b1;
    i_clr_err = 1'b1;
    send_bits(1'b1, 1);
    i_clr_err = 1'b0;
    check("par_cleared", o_parity_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
